// File: rtl/line_input_conditioner_pkg.sv
// line_io_pkg: shared definitions for the line input conditioner.
//   deb_cycles()  - converts a clock rate and a debounce time in ms into cycles
//   state_t       - top-level sequencing states
//   MODE_*        - encodings of the mode DIP switch value
package line_io_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  localparam logic [1:0] MODE_TEST   = 2'd3;

  // Divide first so large clock rates do not overflow a 32-bit int.
  function automatic int deb_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/line_input_conditioner_debounce_cell.sv
// debounce_cell: W-bit debouncer treating its input as one vector.
//   clk, reset : clock, synchronous active-high reset
//   en         : count and accept changes only while high
//   load       : copy din_sync into stable directly (no update)
//   din_sync   : synchronised input value
//   stable     : debounced value
//   update     : high in the cycle whose edge loads a debounced change
module debounce_cell #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] din_sync,
  output logic [W-1:0] stable,
  output logic         update
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] TC  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic          differs;

  assign differs = (din_sync != stable);
  // Combinational so the top can launch its strobe on the same edge that
  // moves stable.
  assign update  = en && !load && differs && (cnt == TC);

  // Any value different from stable keeps the count going, so a multi-bit
  // input that wanders between non-stable values still settles on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      cnt    <= '0;
    end else if (load) begin
      stable <= din_sync;
      cnt    <= '0;
    end else if (en) begin
      if (!differs) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        stable <= din_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/line_input_conditioner.sv
// line_input_conditioner: synchronises and debounces the hook switch, the
// write-mode button and the mode DIP switches, and produces the controller's
// input strobes and levels.
//   clk, reset     : clock, synchronous active-high reset
//   hook_raw       : raw hook switch, 1 = on hook
//   write_btn_raw  : raw write-mode button, 1 = pressed
//   mode_sw_raw    : raw 2-bit mode switches
//   hooked         : PULSE_LEN-cycle strobe, handset placed on hook
//   unhooked       : PULSE_LEN-cycle strobe, handset lifted
//   write_mode     : PULSE_LEN-cycle strobe, button pressed
//   mode_in        : debounced mode value
//   hook_state     : debounced hook level
//   ready          : initial sampling phase complete
//
// state   | meaning
// ST_INIT | sampling raw inputs for DEB_CYCLES, then preload debouncers silently
// ST_RUN  | debouncers active, strobes enabled; left only by reset
//
// DEB_CYCLES must be >= 2 and 1 <= PULSE_LEN <= DEB_CYCLES.
module line_input_conditioner
  import line_io_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int PULSE_LEN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hook_raw,
  input  logic       write_btn_raw,
  input  logic [1:0] mode_sw_raw,
  output logic       hooked,
  output logic       unhooked,
  output logic       write_mode,
  output logic [1:0] mode_in,
  output logic       hook_state,
  output logic       ready
);

  localparam int DEB_CYCLES = deb_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int CW         = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] INIT_TC      = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] ONE          = CW'(1);

  // Bit packing of the raw inputs: {mode[1:0], button, hook}
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode_sw_raw, write_btn_raw, hook_raw};
      sync2 <= sync1;
    end
  end

  state_t        state;
  logic [CW-1:0] init_cnt;
  logic          load;
  logic          en;

  // Down-counter: reaches terminal count on the DEB_CYCLES-th edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= INIT_TC;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == '0) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt - ONE;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  assign load = (state == ST_INIT) && (init_cnt == '0);
  assign en   = (state == ST_RUN);

  logic       hook_stable;
  logic       hook_upd;
  logic       btn_stable;
  logic       btn_upd;
  logic [1:0] mode_stable;
  logic       mode_upd;

  debounce_cell #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_hook_deb (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .din_sync (sync2[0]),
    .stable   (hook_stable),
    .update   (hook_upd)
  );

  debounce_cell #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .din_sync (sync2[1]),
    .stable   (btn_stable),
    .update   (btn_upd)
  );

  debounce_cell #(.W(2), .DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .din_sync (sync2[3:2]),
    .stable   (mode_stable),
    .update   (mode_upd)
  );

  // Mode changes need no strobe; the level output carries them.
  logic mode_upd_unused;
  assign mode_upd_unused = mode_upd;

  // Stretcher index: 0 = hooked, 1 = unhooked, 2 = write_mode.
  // The old stable value (pre-edge) tells the direction of the change.
  logic [2:0]    trig;
  logic [2:0]    strobe_q;
  logic [CW-1:0] str_cnt [3];

  assign trig[0] = hook_upd && !hook_stable;
  assign trig[1] = hook_upd &&  hook_stable;
  assign trig[2] = btn_upd  && !btn_stable;

  // The strobe stays high while the down-counter drains, then drops one edge
  // after it reaches zero, giving exactly PULSE_LEN high cycles. A retrigger
  // reloads the stretch.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= '0;
      for (int i = 0; i < 3; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (trig[i]) begin
          strobe_q[i] <= 1'b1;
          str_cnt[i]  <= PULSE_RELOAD;
        end else if (str_cnt[i] != '0) begin
          str_cnt[i]  <= str_cnt[i] - ONE;
        end else begin
          strobe_q[i] <= 1'b0;
        end
      end
    end
  end

  assign hooked     = strobe_q[0];
  assign unhooked   = strobe_q[1];
  assign write_mode = strobe_q[2];
  assign hook_state = hook_stable;
  assign mode_in    = mode_stable;

endmodule
